// File: rtl/vote_pkg.sv
// Shared types and helpers for the voting-machine front-panel controller.
// Tally and LED widths handled by sat_to_led are limited to MAX_W bits.
package vote_pkg;

    typedef enum logic [1:0] {
        VOTE_IDLE = 2'd0,
        ACK       = 2'd1,
        RESULT    = 2'd2
    } state_e;

    localparam int MAX_W = 32;

    localparam logic [MAX_W-1:0] LED_ALL_ON = '1;

    // Maps a zero-extended tally onto ledW LEDs: values that fit are passed
    // through, anything with a bit at or above ledW saturates to all ones.
    function automatic logic [MAX_W-1:0] sat_to_led(input logic [MAX_W-1:0] tally,
                                                    input int ledW);
        logic [2*MAX_W-1:0] one;
        logic [2*MAX_W-1:0] wide;
        logic [2*MAX_W-1:0] mask;
        one  = {{(2*MAX_W-1){1'b0}}, 1'b1};
        wide = {{MAX_W{1'b0}}, tally};
        mask = (one << ledW) - one;
        if ((wide & ~mask) != '0) begin
            sat_to_led = LED_ALL_ON & mask[MAX_W-1:0];
        end else begin
            sat_to_led = tally & mask[MAX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/vote_display_ctrl_leader_scan.sv
// Round-robin leader scanner: looks at one candidate tally per clock and
// publishes the running maximum once per full sweep of NUM_CAND cycles.
// Ties keep the lower index because later candidates must be strictly larger.
module leader_scan
    import vote_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int VOTE_W   = 8,
    localparam int IDX_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CAND*VOTE_W-1:0] cand_votes,
    output logic [IDX_W-1:0]           leader_idx,
    output logic [VOTE_W-1:0]          leader_tally,
    output logic                       leader_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    logic [IDX_W-1:0]  scanIdx_q;
    logic [IDX_W-1:0]  bestIdx_q;
    logic [IDX_W-1:0]  bestIdx_d;
    logic [VOTE_W-1:0] bestTally_q;
    logic [VOTE_W-1:0] bestTally_d;
    logic [VOTE_W-1:0] curTally;

    // Pick the tally under the scan pointer and fold it into the running best;
    // index 0 restarts the sweep so stale maxima never survive a new sweep.
    always_comb begin
        curTally = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (scanIdx_q == IDX_W'(i)) begin
                curTally = cand_votes[i*VOTE_W +: VOTE_W];
            end
        end
        bestIdx_d   = bestIdx_q;
        bestTally_d = bestTally_q;
        if ((scanIdx_q == '0) || (curTally > bestTally_q)) begin
            bestIdx_d   = scanIdx_q;
            bestTally_d = curTally;
        end
    end

    // Advance the pointer and publish the sweep result on the last candidate.
    always_ff @(posedge clock) begin
        if (reset) begin
            scanIdx_q    <= '0;
            bestIdx_q    <= '0;
            bestTally_q  <= '0;
            leader_idx   <= '0;
            leader_tally <= '0;
            leader_valid <= 1'b0;
        end else begin
            bestIdx_q   <= bestIdx_d;
            bestTally_q <= bestTally_d;
            if (scanIdx_q == LAST_IDX) begin
                scanIdx_q    <= '0;
                leader_idx   <= bestIdx_d;
                leader_tally <= bestTally_d;
                leader_valid <= 1'b1;
            end else begin
                scanIdx_q <= scanIdx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/vote_display_ctrl.sv
// Voting-machine front-panel controller. Voting mode flashes all LEDs for
// HOLD_CYCLES clocks after each vote; result mode shows the tally of the
// lowest-index pressed candidate button.
// Optional feature macro: LEADER_DISPLAY_EN (show the current leader in result
// mode until the first button press).
module vote_display_ctrl
    import vote_pkg::*;
#(
    parameter int NUM_CAND    = 4,
    parameter int VOTE_W      = 8,
    parameter int LED_W       = 8,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mode,
    input  logic                       valid_vote_casted,
    input  logic [NUM_CAND*VOTE_W-1:0] cand_votes,
    input  logic [NUM_CAND-1:0]        cand_btn,
    output logic [LED_W-1:0]           leds,
    output logic                       ack_busy
);

    localparam int               CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LED_W-1:0] LEDS_ON   = LED_ALL_ON[LED_W-1:0];

    state_e           state_q;
    logic [CNT_W-1:0] holdCnt_q;
    logic [LED_W-1:0] leds_q;
    logic             ackBusy_q;
    logic [LED_W-1:0] latch_q;
    logic [LED_W-1:0] latch_d;
    logic [LED_W-1:0] resultLed_d;
    logic [LED_W-1:0] entryLed_d;
    logic             btnHit;
    logic [VOTE_W-1:0] selTally;
    logic [LED_W-1:0] selLed;

`ifdef LEADER_DISPLAY_EN
    localparam int IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

    logic              pressed_q;
    logic              pressed_d;
    logic [VOTE_W-1:0] leaderTally;
    logic              leaderValid;
    logic [LED_W-1:0]  leaderLed;

    leader_scan #(
        .NUM_CAND (NUM_CAND),
        .VOTE_W   (VOTE_W)
    ) uLeaderScan (
        .clock        (clock),
        .reset        (reset),
        .cand_votes   (cand_votes),
        .leader_idx   (),
        .leader_tally (leaderTally),
        .leader_valid (leaderValid)
    );
`endif

    // Resolve the button selection and the value the LEDs would show next in
    // result mode; scanning from the top down lets the lowest index win.
    always_comb begin
        btnHit   = 1'b0;
        selTally = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (cand_btn[i]) begin
                btnHit   = 1'b1;
                selTally = cand_votes[i*VOTE_W +: VOTE_W];
            end
        end
        selLed  = LED_W'(sat_to_led(MAX_W'(selTally), LED_W));
        latch_d = btnHit ? selLed : latch_q;
`ifdef LEADER_DISPLAY_EN
        leaderLed   = leaderValid ? LED_W'(sat_to_led(MAX_W'(leaderTally), LED_W)) : '0;
        pressed_d   = pressed_q | btnHit;
        resultLed_d = pressed_d ? latch_d : leaderLed;
        entryLed_d  = leaderLed;
`else
        resultLed_d = latch_d;
        entryLed_d  = '0;
`endif
    end

    // Main FSM with registered LED and busy outputs; the hold counter only
    // ever loads or counts down to zero, so it cannot wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= VOTE_IDLE;
            holdCnt_q <= '0;
            leds_q    <= '0;
            ackBusy_q <= 1'b0;
            latch_q   <= '0;
`ifdef LEADER_DISPLAY_EN
            pressed_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                VOTE_IDLE: begin
                    if (mode) begin
                        state_q   <= RESULT;
                        holdCnt_q <= '0;
                        ackBusy_q <= 1'b0;
                        latch_q   <= '0;
                        leds_q    <= entryLed_d;
`ifdef LEADER_DISPLAY_EN
                        pressed_q <= 1'b0;
`endif
                    end else if (valid_vote_casted) begin
                        state_q   <= ACK;
                        holdCnt_q <= HOLD_LOAD;
                        ackBusy_q <= 1'b1;
                        leds_q    <= LEDS_ON;
                    end else begin
                        leds_q    <= '0;
                        ackBusy_q <= 1'b0;
                    end
                end
                ACK: begin
                    if (mode) begin
                        state_q   <= RESULT;
                        holdCnt_q <= '0;
                        ackBusy_q <= 1'b0;
                        latch_q   <= '0;
                        leds_q    <= entryLed_d;
`ifdef LEADER_DISPLAY_EN
                        pressed_q <= 1'b0;
`endif
                    end else if (valid_vote_casted) begin
                        holdCnt_q <= HOLD_LOAD;
                        ackBusy_q <= 1'b1;
                        leds_q    <= LEDS_ON;
                    end else if (holdCnt_q == '0) begin
                        state_q   <= VOTE_IDLE;
                        ackBusy_q <= 1'b0;
                        leds_q    <= '0;
                    end else begin
                        holdCnt_q <= holdCnt_q - CNT_W'(1);
                    end
                end
                RESULT: begin
                    if (!mode) begin
                        state_q   <= VOTE_IDLE;
                        ackBusy_q <= 1'b0;
                        leds_q    <= '0;
                    end else begin
                        latch_q   <= latch_d;
                        leds_q    <= resultLed_d;
`ifdef LEADER_DISPLAY_EN
                        pressed_q <= pressed_d;
`endif
                    end
                end
                default: begin
                    state_q   <= VOTE_IDLE;
                    holdCnt_q <= '0;
                    ackBusy_q <= 1'b0;
                    leds_q    <= '0;
                end
            endcase
        end
    end

    assign leds     = leds_q;
    assign ack_busy = ackBusy_q;

endmodule

// File: tb/tb_vote_display_ctrl.sv
// Self-checking bench for vote_display_ctrl: a vector table for the directed
// cases, hand sequences for hold timing, saturation and leader display, and a
// randomized run compared against a behavioural model.
// Honours LEADER_DISPLAY_EN when it is defined for the build.
module tb_vote_display_ctrl;

    localparam int NUM_CAND = 4;
    localparam int VOTE_W   = 8;
    localparam int LED_W    = 8;
    localparam int HOLD     = 10;

`ifdef LEADER_DISPLAY_EN
    localparam bit LEADER_ON = 1'b1;
`else
    localparam bit LEADER_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic        validVote = 1'b0;
    logic [31:0] candVotes = 32'h0;
    logic [3:0]  candBtn = 4'h0;
    logic [7:0]  leds;
    logic        ackBusy;

    logic        reset10 = 1'b1;
    logic        mode10 = 1'b0;
    logic        vote10 = 1'b0;
    logic [39:0] votes10 = 40'h0;
    logic [3:0]  btn10 = 4'h0;
    logic [7:0]  leds10;
    logic        busy10;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    vote_display_ctrl #(
        .NUM_CAND    (NUM_CAND),
        .VOTE_W      (VOTE_W),
        .LED_W       (LED_W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .mode              (mode),
        .valid_vote_casted (validVote),
        .cand_votes        (candVotes),
        .cand_btn          (candBtn),
        .leds              (leds),
        .ack_busy          (ackBusy)
    );

    vote_display_ctrl #(
        .NUM_CAND    (4),
        .VOTE_W      (10),
        .LED_W       (8),
        .HOLD_CYCLES (HOLD)
    ) dut10 (
        .clock             (clock),
        .reset             (reset10),
        .mode              (mode10),
        .valid_vote_casted (vote10),
        .cand_votes        (votes10),
        .cand_btn          (btn10),
        .leds              (leds10),
        .ack_busy          (busy10)
    );

    typedef struct {
        logic       rst;
        logic       md;
        logic       vote;
        logic [3:0] btn;
        logic [7:0] expLeds;
        logic       expBusy;
        string      name;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state: lit cycles remaining, result flag, latch.
    bit         mInResult;
    bit         mPressed;
    int         mAckLeft;
    logic [7:0] mLatch;
    logic [7:0] mLeds;
    logic       mBusy;

    task automatic addVec(input logic rst, input logic md, input logic vote,
                          input logic [3:0] btn, input logic [7:0] expLeds,
                          input logic expBusy, input string name);
        vec_t v;
        v.rst = rst; v.md = md; v.vote = vote; v.btn = btn;
        v.expLeds = expLeds; v.expBusy = expBusy; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic rst, input logic md, input logic vote,
                                 input logic [3:0] btn);
        reset = rst;
        mode = md;
        validVote = vote;
        candBtn = btn;
        @(posedge clock);
        #1;
    endtask

    task automatic checkLeds(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s leds: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expLeds, input logic expBusy);
        checkLeds(name, leds, expLeds);
        checks++;
        if (ackBusy !== expBusy) begin
            failures++;
            $display("[TB] FAIL %s ack_busy: got %0b expected %0b", name, ackBusy, expBusy);
        end
    endtask

    function automatic logic [7:0] tallyOf(input int idx);
        logic [31:0] v;
        v = candVotes;
        return v[idx*8 +: 8];
    endfunction

    function automatic logic [7:0] leaderTally();
        logic [7:0] best;
        best = tallyOf(0);
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tallyOf(i) > best) best = tallyOf(i);
        end
        return best;
    endfunction

    task automatic modelReset();
        mInResult = 1'b0;
        mPressed  = 1'b0;
        mAckLeft  = 0;
        mLatch    = 8'h00;
        mLeds     = 8'h00;
        mBusy     = 1'b0;
    endtask

    // One clock of the panel behaviour, expressed as "lit clocks remaining"
    // in voting mode and a latch of the chosen tally in result mode.
    task automatic modelStep(input logic md, input logic vote, input logic [3:0] btn);
        if (!mInResult) begin
            if (md) begin
                mInResult = 1'b1;
                mAckLeft  = 0;
                mLatch    = 8'h00;
                mPressed  = 1'b0;
                mLeds     = LEADER_ON ? leaderTally() : 8'h00;
            end else begin
                if (vote) mAckLeft = HOLD;
                else if (mAckLeft > 0) mAckLeft--;
                mLeds = (mAckLeft > 0) ? 8'hFF : 8'h00;
            end
        end else begin
            if (!md) begin
                mInResult = 1'b0;
                mLeds     = 8'h00;
            end else begin
                for (int i = 0; i < NUM_CAND; i++) begin
                    if (btn[i]) begin
                        mLatch   = tallyOf(i);
                        mPressed = 1'b1;
                        break;
                    end
                end
                mLeds = (LEADER_ON && !mPressed) ? leaderTally() : mLatch;
            end
        end
        mBusy = !mInResult && (mAckLeft > 0);
    endtask

    // Overall time limit so the bench always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] leaderExp;
        logic [7:0] got;
        bool_dummy: begin end
        leaderExp = LEADER_ON ? 8'h22 : 8'h00;
        candVotes = 32'h09_05_22_11;

        // Directed vectors: reset, reset mid-ACK, mode abort, result select.
        addVec(1, 0, 0, 4'b0000, 8'h00, 0, "reset");
        addVec(0, 0, 1, 4'b0000, 8'hFF, 1, "t1 vote");
        addVec(0, 0, 0, 4'b0000, 8'hFF, 1, "t1 ack1");
        addVec(0, 0, 0, 4'b0000, 8'hFF, 1, "t1 ack2");
        addVec(1, 0, 0, 4'b0000, 8'h00, 0, "t1 reset mid ack");
        addVec(0, 0, 0, 4'b0000, 8'h00, 0, "t1 idle after reset");
        addVec(0, 0, 1, 4'b0000, 8'hFF, 1, "t4 vote");
        addVec(0, 0, 0, 4'b0000, 8'hFF, 1, "t4 ack1");
        addVec(0, 0, 0, 4'b0000, 8'hFF, 1, "t4 ack2");
        addVec(0, 0, 0, 4'b0000, 8'hFF, 1, "t4 ack3");
        addVec(0, 1, 0, 4'b0000, leaderExp, 0, "t4 abort");
        addVec(0, 1, 1, 4'b0000, leaderExp, 0, "t4 vote ignored a");
        addVec(0, 1, 1, 4'b0000, leaderExp, 0, "t4 vote ignored b");
        addVec(0, 0, 0, 4'b0000, 8'h00, 0, "t4 back to idle");
        addVec(0, 0, 0, 4'b0000, 8'h00, 0, "t4 idle");
        addVec(0, 0, 1, 4'b0000, 8'hFF, 1, "t4 vote again");
        addVec(0, 1, 0, 4'b0000, leaderExp, 0, "t3 enter result");
        addVec(0, 1, 0, 4'b0100, 8'h05, 0, "t3 btn2");
        addVec(0, 1, 0, 4'b0000, 8'h05, 0, "t3 release holds");
        addVec(0, 1, 0, 4'b0110, 8'h22, 0, "t3 btn1 wins");
        addVec(0, 1, 0, 4'b0001, 8'h11, 0, "t3 btn0");
        addVec(0, 1, 0, 4'b0000, 8'h11, 0, "t3 release holds 2");
        addVec(0, 1, 0, 4'b1000, 8'h09, 0, "t3 btn3");
        addVec(0, 0, 0, 4'b1000, 8'h00, 0, "t3 exit result");
        addVec(0, 0, 0, 4'b0000, 8'h00, 0, "t3 idle");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].md, vecs[i].vote, vecs[i].btn);
            checkOutput(vecs[i].name, vecs[i].expLeds, vecs[i].expBusy);
        end

        // Isolated vote: exactly HOLD lit clocks, then dark.
        applyStimulus(0, 0, 1, 4'b0000);
        checkOutput("t2 single pulse", 8'hFF, 1);
        for (int k = 1; k < HOLD; k++) begin
            applyStimulus(0, 0, 0, 4'b0000);
            checkOutput($sformatf("t2 single hold %0d", k), 8'hFF, 1);
        end
        applyStimulus(0, 0, 0, 4'b0000);
        checkOutput("t2 single end", 8'h00, 0);

        // Second vote five cycles into ACK extends the hold.
        applyStimulus(0, 0, 1, 4'b0000);
        checkOutput("t2 first pulse", 8'hFF, 1);
        for (int k = 1; k < 5; k++) begin
            applyStimulus(0, 0, 0, 4'b0000);
            checkOutput($sformatf("t2 pre extend %0d", k), 8'hFF, 1);
        end
        applyStimulus(0, 0, 1, 4'b0000);
        checkOutput("t2 second pulse", 8'hFF, 1);
        for (int k = 1; k < HOLD; k++) begin
            applyStimulus(0, 0, 0, 4'b0000);
            checkOutput($sformatf("t2 extended hold %0d", k), 8'hFF, 1);
        end
        applyStimulus(0, 0, 0, 4'b0000);
        checkOutput("t2 extended end", 8'h00, 0);

        // Saturation with 10-bit tallies on 8 LEDs.
        votes10 = {10'h080, 10'h07F, 10'h100, 10'h0FF};
        reset10 = 1'b1;
        @(posedge clock); #1;
        checkLeds("t5 reset", leds10, 8'h00);
        reset10 = 1'b0;
        mode10  = 1'b1;
        @(posedge clock); #1;
        btn10 = 4'b0001;
        @(posedge clock); #1;
        checkLeds("t5 tally 0x0FF", leds10, 8'hFF);
        btn10 = 4'b0010;
        @(posedge clock); #1;
        checkLeds("t5 tally 0x100", leds10, 8'hFF);
        btn10 = 4'b0100;
        @(posedge clock); #1;
        checkLeds("t5 tally 0x07F", leds10, 8'h7F);
        btn10 = 4'b1000;
        @(posedge clock); #1;
        checkLeds("t5 tally 0x080", leds10, 8'h80);
        btn10 = 4'b0000;
        @(posedge clock); #1;
        checkLeds("t5 hold", leds10, 8'h80);

        // Leader display on result entry (cand 1 wins the 7/7 tie).
        candVotes = 32'h01_07_07_03;
        applyStimulus(1, 0, 0, 4'b0000);
        checkOutput("t6 reset", 8'h00, 0);
        for (int k = 0; k < 2 * NUM_CAND; k++) applyStimulus(0, 0, 0, 4'b0000);
        got = 8'hAA;
        for (int k = 0; k <= NUM_CAND; k++) begin
            applyStimulus(0, 1, 0, 4'b0000);
            got = leds;
            if (got == (LEADER_ON ? 8'h07 : 8'h00)) break;
        end
        checkLeds("t6 leader display", got, LEADER_ON ? 8'h07 : 8'h00);
        applyStimulus(0, 0, 0, 4'b0000);

        // Randomized segments against the behavioural model.
        for (int seg = 0; seg < 3; seg++) begin
            logic       md;
            logic       vote;
            logic [3:0] btn;
            candVotes = $urandom;
            applyStimulus(1, 0, 0, 4'b0000);
            modelReset();
            checkOutput($sformatf("rand seg%0d reset", seg), mLeds, mBusy);
            md = 1'b0;
            for (int c = 0; c < 300; c++) begin
                if (c < 2 * NUM_CAND) begin
                    vote = 1'b0;
                    btn  = 4'b0000;
                end else begin
                    if ($urandom_range(0, 7) == 0) md = ~md;
                    vote = ($urandom_range(0, 2) == 0);
                    btn  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
                end
                modelStep(md, vote, btn);
                applyStimulus(0, md, vote, btn);
                checkOutput($sformatf("rand seg%0d cyc%0d", seg, c), mLeds, mBusy);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
